// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types and widths: tag/index geometry and the
// write-tag buffer payload used by the tag-RAM write arbiter.
package vector_cache_pkg;

    localparam int TAG_WIDTH   = 12;
    localparam int INDEX_WIDTH = 8;
    localparam int WAY_NUM     = 4;

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] index;
        logic [TAG_WIDTH-1:0]   tag;
        logic [WAY_NUM-1:0]     way_oh;
    } wr_buf_pld_t;

endpackage

// File: rtl/vec_cache_rr_arb.sv
// Parameterised round-robin arbiter: scans from ptr upward with wrap, and
// advances ptr past the winner whenever a grant is issued.
module vec_cache_rr_arb #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [PW-1:0] ptr;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N))
                sum = sum - (PW+1)'(N);
            idx = sum[PW-1:0];
            if (!gnt_vld && en && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt_idx  = idx;
                gnt[idx] = 1'b1;
            end
        end
    end

    // Winner drops to lowest priority for the next round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (gnt_vld)
            ptr <= (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + 1'b1;
    end

endmodule

// File: rtl/vec_cache_tag_wr_arb.sv
// Tag-RAM write-port arbiter: round-robin over write-tag buffers into a
// one-deep registered write stage, plus a combinational index-hazard check.
module vec_cache_tag_wr_arb
    import vector_cache_pkg::*;
#(
    parameter  int REQ_NUM = 4,
    localparam int PW      = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic        [REQ_NUM-1:0]     req_vld,
    input  wr_buf_pld_t [REQ_NUM-1:0]     req_pld,
    output logic        [REQ_NUM-1:0]     req_rdy,
    output logic                          ram_wr_en,
    output logic        [INDEX_WIDTH-1:0] ram_wr_index,
    output logic        [TAG_WIDTH-1:0]   ram_wr_tag,
    output logic        [WAY_NUM-1:0]     ram_wr_way_oh,
    input  logic                          ram_wr_rdy,
    input  logic        [INDEX_WIDTH-1:0] chk_index,
    output logic                          chk_hit,
    output logic                          idle
);

    wr_buf_pld_t   stage;
    logic          stage_free;
    logic [PW-1:0] gnt_idx;
    logic          gnt_vld;

    // Draining and reloading the stage can happen in the same cycle.
    assign stage_free = !ram_wr_en || ram_wr_rdy;

    vec_cache_rr_arb #(.N(REQ_NUM)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_vld),
        .en      (stage_free),
        .gnt     (req_rdy),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_wr_en <= 1'b0;
            stage     <= '0;
        end else if (gnt_vld) begin
            ram_wr_en <= 1'b1;
            stage     <= req_pld[gnt_idx];
        end else if (ram_wr_rdy) begin
            ram_wr_en <= 1'b0;
        end
    end

    assign ram_wr_index  = stage.index;
    assign ram_wr_tag    = stage.tag;
    assign ram_wr_way_oh = stage.way_oh;

    // Hazard covers both queued requests and the write sitting in the stage.
    always_comb begin
        chk_hit = ram_wr_en && (stage.index == chk_index);
        for (int i = 0; i < REQ_NUM; i++)
            if (req_vld[i] && req_pld[i].index == chk_index)
                chk_hit = 1'b1;
    end

    assign idle = !(|req_vld) && !ram_wr_en;

endmodule

// File: tb/tb_vec_cache_tag_wr_arb.sv
// Self-checking bench for vec_cache_tag_wr_arb: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_vec_cache_tag_wr_arb;
    import vector_cache_pkg::*;

    localparam int N = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N-1:0]           req_vld;
    wr_buf_pld_t [N-1:0]    req_pld;
    logic [N-1:0]           req_rdy;
    logic                   ram_wr_en;
    logic [INDEX_WIDTH-1:0] ram_wr_index;
    logic [TAG_WIDTH-1:0]   ram_wr_tag;
    logic [WAY_NUM-1:0]     ram_wr_way_oh;
    logic                   ram_wr_rdy;
    logic [INDEX_WIDTH-1:0] chk_index;
    logic                   chk_hit;
    logic                   idle;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int          m_ptr;
    bit          m_en;
    wr_buf_pld_t m_pld;

    vec_cache_tag_wr_arb #(.REQ_NUM(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_vld       (req_vld),
        .req_pld       (req_pld),
        .req_rdy       (req_rdy),
        .ram_wr_en     (ram_wr_en),
        .ram_wr_index  (ram_wr_index),
        .ram_wr_tag    (ram_wr_tag),
        .ram_wr_way_oh (ram_wr_way_oh),
        .ram_wr_rdy    (ram_wr_rdy),
        .chk_index     (chk_index),
        .chk_hit       (chk_hit),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    function automatic int m_grant();
        if (m_en && !ram_wr_rdy) return -1;
        for (int k = 0; k < N; k++)
            if (req_vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] m_rdy();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = m_grant();
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic bit m_hit();
        bit h;
        h = m_en && (m_pld.index == chk_index);
        for (int i = 0; i < N; i++)
            if (req_vld[i] && req_pld[i].index == chk_index) h = 1;
        return h;
    endfunction

    task automatic clr_inputs();
        req_vld    = '0;
        req_pld    = '0;
        ram_wr_rdy = 1'b0;
        chk_index  = '0;
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_en  = 0;
        m_pld = '0;
    endtask

    // advance one clock, updating the model from the inputs held across the edge
    task automatic tick();
        int g;
        g = m_grant();
        @(posedge clk);
        if (g >= 0) begin
            m_en  = 1;
            m_pld = req_pld[g];
            m_ptr = (g + 1) % N;
        end else if (ram_wr_rdy) begin
            m_en = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clr_inputs();
        rst_n = 1'b0;
        model_reset();
        #3;
        total++;
        if (ram_wr_en !== 1'b0 || ram_wr_index !== '0 || ram_wr_tag !== '0 || ram_wr_way_oh !== '0) begin
            bad++; $display("FAIL reset_outputs got en=%b idx=%h tag=%h way=%b want all 0",
                            ram_wr_en, ram_wr_index, ram_wr_tag, ram_wr_way_oh);
        end
        total++;
        if (req_rdy !== '0 || idle !== 1'b1 || chk_hit !== 1'b0) begin
            bad++; $display("FAIL reset_comb got rdy=%b idle=%b hit=%b want 0000/1/0", req_rdy, idle, chk_hit);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req_vld = 4'b0001;
        req_pld[0] = '{index: 8'h12, tag: 12'h3A5, way_oh: 4'b0100};
        ram_wr_rdy = 1'b1;
        #1;
        total++;
        if (req_rdy !== 4'b0001) begin bad++; $display("FAIL single_rdy got %b want 0001", req_rdy); end
        tick();
        req_vld = '0;
        #1;
        total++;
        if (ram_wr_en !== 1'b1 || ram_wr_index !== 8'h12 || ram_wr_tag !== 12'h3A5 || ram_wr_way_oh !== 4'b0100) begin
            bad++; $display("FAIL single_stage got en=%b idx=%h tag=%h way=%b want 1/12/3a5/0100",
                            ram_wr_en, ram_wr_index, ram_wr_tag, ram_wr_way_oh);
        end
        tick();
        total++;
        if (ram_wr_en !== 1'b0) begin bad++; $display("FAIL single_drain got en=%b want 0", ram_wr_en); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        do_reset();
        req_vld = '1;
        ram_wr_rdy = 1'b1;
        for (int i = 0; i < N; i++) req_pld[i] = '{index: 8'(i), tag: 12'(16 * i), way_oh: 4'b0001};
        for (int c = 0; c < 5; c++) begin
            #1;
            want = 4'b0001 << (c % N);
            total++;
            if (req_rdy !== want || ram_wr_en !== (c > 0)) begin
                bad++; $display("FAIL rr_cycle%0d got rdy=%b en=%b want %b/%b", c, req_rdy, ram_wr_en, want, c > 0);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_vld = 4'b0001;
        req_pld[0] = '{index: 8'h05, tag: 12'h111, way_oh: 4'b0010};
        tick();
        req_vld = 4'b0100;
        req_pld[2] = '{index: 8'h77, tag: 12'h222, way_oh: 4'b1000};
        ram_wr_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++;
            if (ram_wr_en !== 1'b1 || ram_wr_index !== 8'h05 || ram_wr_tag !== 12'h111 || req_rdy !== '0) begin
                bad++; $display("FAIL bp_hold%0d got en=%b idx=%h tag=%h rdy=%b want 1/05/111/0000",
                                c, ram_wr_en, ram_wr_index, ram_wr_tag, req_rdy);
            end
            tick();
        end
        ram_wr_rdy = 1'b1;
        #1;
        total++;
        if (req_rdy !== 4'b0100) begin bad++; $display("FAIL bp_release_rdy got %b want 0100", req_rdy); end
        tick();
        req_vld = '0;
        #1;
        total++;
        if (ram_wr_en !== 1'b1 || ram_wr_index !== 8'h77 || ram_wr_tag !== 12'h222) begin
            bad++; $display("FAIL bp_reload got en=%b idx=%h tag=%h want 1/77/222", ram_wr_en, ram_wr_index, ram_wr_tag);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        ram_wr_rdy = 1'b1;
        req_vld = 4'b0100;
        tick();
        req_vld = 4'b1001;
        req_pld[3] = '{index: 8'h33, tag: 12'h333, way_oh: 4'b0001};
        req_pld[0] = '{index: 8'h30, tag: 12'h300, way_oh: 4'b0010};
        #1;
        total++;
        if (req_rdy !== 4'b1000) begin bad++; $display("FAIL wrap_g3 got %b want 1000", req_rdy); end
        tick();
        req_vld = 4'b0001;
        #1;
        total++;
        if (req_rdy !== 4'b0001 || ram_wr_index !== 8'h33) begin
            bad++; $display("FAIL wrap_g0 got rdy=%b idx=%h want 0001/33", req_rdy, ram_wr_index);
        end
        tick();
        req_vld = 4'b0011;
        #1;
        total++;
        if (req_rdy !== 4'b0010) begin bad++; $display("FAIL wrap_ptr1 got %b want 0010", req_rdy); end
        tick();
        req_vld = '0;
        tick();
    endtask

    task automatic test_hazard();
        do_reset();
        req_vld = 4'b0001;
        req_pld[0].index = 8'h41;
        tick();
        req_vld = 4'b0010;
        req_pld[1].index = 8'h40;
        chk_index = 8'h40;
        #1;
        total++;
        if (chk_hit !== 1'b1) begin bad++; $display("FAIL hz_req got %b want 1", chk_hit); end
        chk_index = 8'h41;
        #1;
        total++;
        if (chk_hit !== 1'b1) begin bad++; $display("FAIL hz_stage got %b want 1", chk_hit); end
        chk_index = 8'h42;
        #1;
        total++;
        if (chk_hit !== 1'b0) begin bad++; $display("FAIL hz_miss got %b want 0", chk_hit); end
        ram_wr_rdy = 1'b1;
        tick();
        req_vld = '0;
        tick();
        chk_index = 8'h40;
        #1;
        total++;
        if (chk_hit !== 1'b0 || idle !== 1'b1) begin
            bad++; $display("FAIL hz_drained got hit=%b idle=%b want 0/1", chk_hit, idle);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        req_vld = 4'b0100;
        tick();
        req_vld = '0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (ram_wr_en !== 1'b0) begin bad++; $display("FAIL midrst_en got %b want 0", ram_wr_en); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        req_vld = 4'b1100;
        ram_wr_rdy = 1'b1;
        #1;
        total++;
        if (req_rdy !== 4'b0100) begin bad++; $display("FAIL midrst_first got %b want 0100", req_rdy); end
        tick();
        req_vld = '0;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] want_rdy;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_vld    = 4'($urandom_range(0, 15));
            ram_wr_rdy = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 1) == 1)
                    req_pld[i] = '{index: 8'($urandom_range(0, 7)), tag: 12'($urandom),
                                   way_oh: 4'($urandom)};
            chk_index = 8'($urandom_range(0, 7));
            #1;
            want_rdy = m_rdy();
            total++;
            if (req_rdy !== want_rdy || chk_hit !== m_hit() || ram_wr_en !== m_en ||
                idle !== (req_vld == '0 && !m_en)) begin
                bad++; $display("FAIL rnd_ctl%0d got rdy=%b hit=%b en=%b idle=%b want %b/%b/%b/%b", c,
                                req_rdy, chk_hit, ram_wr_en, idle, want_rdy, m_hit(), m_en, req_vld == '0 && !m_en);
            end
            if (m_en) begin
                total++;
                if ({ram_wr_index, ram_wr_tag, ram_wr_way_oh} !== m_pld) begin
                    bad++; $display("FAIL rnd_pld%0d got %h want %h", c,
                                    {ram_wr_index, ram_wr_tag, ram_wr_way_oh}, m_pld);
                end
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clr_inputs();
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_hazard();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
